// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, single-outstanding imem handshake, small {pc, word} buffer.
// Optional build macro FETCH_PC8_EN: instr_pc reports the stored PC + 8 (ARM R15 read value).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t        fifo_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   tag_pc_q, tag_pc_d;
  logic          outstanding_q, outstanding_d;
  logic          discard_q, discard_d;

  logic [CW:0]   used;
  logic          credit, grant, rsp, push, pop;
  entry_t        head;
  logic [31:0]   head_pc;
  logic          unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^branch_target[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Issue credit: buffered plus in-flight words must leave room for one more
  assign used     = (CW+1)'(count_q) + (CW+1)'(outstanding_q);
  assign credit   = used < (CW+1)'(DEPTH);
  assign imem_req = rst & credit & ~outstanding_q & ~branch_en;
  assign imem_addr = fetch_pc_q;

  assign grant = imem_req & imem_gnt;
  assign rsp   = imem_rvalid & (outstanding_q | discard_q);
  assign push  = rst & rsp & ~discard_q & ~branch_en;
  assign pop   = instr_valid & instr_ready & ~branch_en;

  // Next-state logic
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    tag_pc_d      = tag_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (rsp) begin
      outstanding_d = 1'b0;
      discard_d     = 1'b0;
    end
    if (grant) begin
      outstanding_d = 1'b1;
      tag_pc_d      = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + PC_STEP;
    end
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Redirect flushes the buffer; a response still in flight is marked for dropping
    if (branch_en) begin
      fetch_pc_d = {branch_target[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      if (!imem_rvalid) discard_d = discard_q | outstanding_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
      tag_pc_q      <= '0;
      outstanding_q <= 1'b0;
      // A response in flight across reset must not be delivered afterwards
      discard_q     <= (discard_q | outstanding_q) & ~imem_rvalid;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      tag_pc_q      <= tag_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{pc: tag_pc_q, word: imem_rdata};
  end

  // Head presentation; zeros when empty
  assign head        = fifo_q[rd_ptr_q];
  assign instr_valid = (count_q != '0);
`ifdef FETCH_PC8_EN
  assign head_pc = head.pc + 32'd8;
`else
  assign head_pc = head.pc;
`endif
  assign instr    = instr_valid ? head.word : 32'h0;
  assign instr_pc = instr_valid ? head_pc : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected {pc, word} queued on each live response, checked on pop.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  exp_t        exp_q[$];
  int          checks;
  int          errors;
  int          pops;
  logic        auto_rsp;
  logic        rsp_live;
  logic [31:0] rsp_pc;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .branch_en(branch_en), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hE3A0_0001 ^ {a[27:0], 4'h0};
  endfunction

  function automatic logic [31:0] pc_view(input logic [31:0] pc);
`ifdef FETCH_PC8_EN
    return pc + 32'd8;
`else
    return pc;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: score the edge about to happen, then model a 1-cycle memory when enabled
  task automatic tick();
    logic        g;
    logic [31:0] a;
    exp_t        e;
    #1;
    g = imem_req & imem_gnt;
    a = imem_addr;
    if (!rst || branch_en) begin
      exp_q.delete();
    end else begin
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_instr", 32'(instr_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("instr", instr, e.word);
          check("instr_pc", instr_pc, pc_view(e.pc));
          pops++;
        end
      end
      if (imem_rvalid && rsp_live) exp_q.push_back('{pc: rsp_pc, word: imem_rdata});
    end
    @(posedge clk);
    @(negedge clk);
    if (auto_rsp) begin
      imem_rvalid = g;
      imem_rdata  = g ? word_of(a) : 32'h0;
      rsp_pc      = a;
      rsp_live    = g;
    end
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; pops = 0;
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    branch_en = 1'b0; branch_target = 32'h0; instr_ready = 1'b0;
    auto_rsp = 1'b1; rsp_live = 1'b0; rsp_pc = 32'h0;

    // Reset and startup
    @(negedge clk);
    repeat (3) tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    rst = 1'b1;
    #1;
    check("start_req", 32'(imem_req), 32'd1);
    check("start_addr", imem_addr, 32'h0);
    imem_gnt = 1'b1;
    tick();
    check("req_while_outstanding", 32'(imem_req), 32'd0);
    tick();
    check("lat_valid", 32'(instr_valid), 32'd1);
    check("lat_instr", instr, 32'hE3A0_0001);
    check("lat_pc", instr_pc, pc_view(32'h0));

    // Backpressure: buffer fills, issue stops, then drains in order
    repeat (4) tick();
    check("bp_req", 32'(imem_req), 32'd0);
    check("bp_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    tick();
    check("resume_req", 32'(imem_req), 32'd1);
    check("resume_addr", imem_addr, 32'h8);
    pops = 0;
    repeat (10) tick();
    check("throughput", 32'(pops), 32'd5);
    imem_gnt = 1'b0;
    repeat (4) tick();
    check("drain_valid", 32'(instr_valid), 32'd0);
    check("drain_sb", 32'(exp_q.size()), 32'd0);

    // Redirect with nothing outstanding, then flush with a response outstanding
    branch_en = 1'b1; branch_target = 32'h10;
    tick();
    branch_en = 1'b0;
    #1;
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", imem_addr, 32'h10);
    auto_rsp = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    branch_en = 1'b1; branch_target = 32'h103;
    tick();
    branch_en = 1'b0;
    #1;
    check("flush_req", 32'(imem_req), 32'd0);
    check("flush_addr", imem_addr, 32'h100);
    check("flush_valid", 32'(instr_valid), 32'd0);
    repeat (2) tick();
    check("stale_wait_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; rsp_live = 1'b0;
    tick();
    imem_rvalid = 1'b0;
    check("post_stale_req", 32'(imem_req), 32'd1);
    check("post_stale_addr", imem_addr, 32'h100);
    check("post_stale_valid", 32'(instr_valid), 32'd0);

    // Branch, response and pop in the same cycle
    auto_rsp = 1'b1; imem_gnt = 1'b1; instr_ready = 1'b0;
    repeat (3) tick();
    check("sim_pre_valid", 32'(instr_valid), 32'd1);
    check("sim_pre_rvalid", 32'(imem_rvalid), 32'd1);
    branch_en = 1'b1; branch_target = 32'h200; instr_ready = 1'b1;
    tick();
    branch_en = 1'b0;
    #1;
    check("sim_valid", 32'(instr_valid), 32'd0);
    check("sim_req", 32'(imem_req), 32'd1);
    check("sim_addr", imem_addr, 32'h200);

    // Address hold under no grant, then wrap past the top of the address space
    imem_gnt = 1'b0;
    branch_en = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    branch_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_addr", imem_addr, 32'hFFFF_FFFC);
      check("hold_req", 32'(imem_req), 32'd1);
    end
    imem_gnt = 1'b1;
    tick();
    check("wrap_busy_req", 32'(imem_req), 32'd0);
    tick();
    check("wrap_req", 32'(imem_req), 32'd1);
    check("wrap_addr", imem_addr, 32'h0);
    tick();
    imem_gnt = 1'b0;
    repeat (3) tick();
    check("wrap_drain_valid", 32'(instr_valid), 32'd0);
    check("wrap_drain_sb", 32'(exp_q.size()), 32'd0);

    // Reset with a response outstanding; the late word must be dropped
    auto_rsp = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b0;
    tick();
    imem_gnt = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    check("midrst_req", 32'(imem_req), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_start_req", 32'(imem_req), 32'd1);
    check("midrst_start_addr", imem_addr, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD; rsp_live = 1'b0;
    tick();
    imem_rvalid = 1'b0;
    check("midrst_drop_valid", 32'(instr_valid), 32'd0);
    auto_rsp = 1'b1; imem_gnt = 1'b1; instr_ready = 1'b1;
    repeat (2) tick();
    check("midrst_first_pc", instr_pc, pc_view(32'h0));
    tick();
    imem_gnt = 1'b0;
    repeat (3) tick();
    check("end_valid", 32'(instr_valid), 32'd0);
    check("end_sb", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
